// File: rtl/fetch_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : fetch_sequencer
// Brief    : PC/fetch controller. Resolves JUMP/HALT internally and forwards
//            all other instructions over valid/ready. Optional macro
//            FETCH_STATS_EN adds the retired_cnt handshake counter.
// Revision : 1.0
// ============================================================================
module fetch_sequencer #(
  parameter int              ADDR_W       = 8,
  parameter logic [ADDR_W-1:0] RESET_PC   = '0,
  parameter int              INSTR_STRIDE = 3,
  parameter logic [2:0]      OP_JUMP      = 3'b100,
  parameter logic [2:0]      OP_HALT      = 3'b111
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [2:0]        mem_opcode,
  input  logic [7:0]        mem_a,
  input  logic [7:0]        mem_b,
  output logic              ins_valid,
  input  logic              ins_ready,
  output logic [2:0]        ins_opcode,
  output logic [7:0]        ins_a,
  output logic [7:0]        ins_b,
  output logic              halted
`ifdef FETCH_STATS_EN
  ,
  output logic [15:0]       retired_cnt
`endif
);

  localparam logic [ADDR_W-1:0] C_STRIDE = ADDR_W'(INSTR_STRIDE);

  typedef enum logic [1:0] {
    S_FETCH   = 2'd0,
    S_DECODE  = 2'd1,
    S_PRESENT = 2'd2,
    S_HALT    = 2'd3
  } state_t;

  state_t            r_state, w_state_nx;
  logic [ADDR_W-1:0] r_pc, w_pc_nx;
  logic              r_valid, w_valid_nx;
  logic [2:0]        r_op, w_op_nx;
  logic [7:0]        r_a, w_a_nx;
  logic [7:0]        r_b, w_b_nx;
  logic              r_halted, w_halted_nx;
  logic              w_handshake;

  assign w_handshake = (r_state == S_PRESENT) && ins_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= S_FETCH;
      r_pc     <= RESET_PC;
      r_valid  <= 1'b0;
      r_op     <= '0;
      r_a      <= '0;
      r_b      <= '0;
      r_halted <= 1'b0;
    end else begin
      r_state  <= w_state_nx;
      r_pc     <= w_pc_nx;
      r_valid  <= w_valid_nx;
      r_op     <= w_op_nx;
      r_a      <= w_a_nx;
      r_b      <= w_b_nx;
      r_halted <= w_halted_nx;
    end
  end

  always_comb begin
    w_state_nx  = r_state;
    w_pc_nx     = r_pc;
    w_valid_nx  = r_valid;
    w_op_nx     = r_op;
    w_a_nx      = r_a;
    w_b_nx      = r_b;
    w_halted_nx = r_halted;
    case (r_state)
      S_FETCH: begin
        if (en) w_state_nx = S_DECODE;
      end
      S_DECODE: begin
        // Memory read data is valid here: it sampled r_pc on the FETCH edge.
        if (mem_opcode == OP_JUMP) begin
          w_pc_nx    = ADDR_W'(mem_a);
          w_state_nx = S_FETCH;
        end else if (mem_opcode == OP_HALT) begin
          w_halted_nx = 1'b1;
          w_state_nx  = S_HALT;
        end else begin
          w_op_nx    = mem_opcode;
          w_a_nx     = mem_a;
          w_b_nx     = mem_b;
          w_valid_nx = 1'b1;
          w_state_nx = S_PRESENT;
        end
      end
      S_PRESENT: begin
        if (w_handshake) begin
          w_valid_nx = 1'b0;
          w_pc_nx    = r_pc + C_STRIDE;
          w_state_nx = S_FETCH;
        end
      end
      default: begin
        w_state_nx = S_HALT;
      end
    endcase
  end

  assign mem_addr   = r_pc;
  assign ins_valid  = r_valid;
  assign ins_opcode = r_op;
  assign ins_a      = r_a;
  assign ins_b      = r_b;
  assign halted     = r_halted;

`ifdef FETCH_STATS_EN
  logic [15:0] r_retired;

  always_ff @(posedge clk) begin
    if (rst)              r_retired <= '0;
    else if (w_handshake) r_retired <= r_retired + 16'd1;
  end

  assign retired_cnt = r_retired;
`endif

endmodule
`default_nettype wire

// File: tb/tb_fetch_sequencer.sv
`default_nettype none
// Directed bench for fetch_sequencer with a registered-read instruction memory model.
module tb_fetch_sequencer;

  logic       clk = 1'b0;
  logic       rst, en, ins_ready;
  logic [7:0] mem_addr;
  logic [2:0] mem_opcode;
  logic [7:0] mem_a, mem_b;
  logic       ins_valid;
  logic [2:0] ins_opcode;
  logic [7:0] ins_a, ins_b;
  logic       halted;
`ifdef FETCH_STATS_EN
  logic [15:0] retired_cnt;
`endif

  logic [7:0] mem [256];
  int n_vec = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  fetch_sequencer dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .mem_addr   (mem_addr),
    .mem_opcode (mem_opcode),
    .mem_a      (mem_a),
    .mem_b      (mem_b),
    .ins_valid  (ins_valid),
    .ins_ready  (ins_ready),
    .ins_opcode (ins_opcode),
    .ins_a      (ins_a),
    .ins_b      (ins_b),
    .halted     (halted)
`ifdef FETCH_STATS_EN
    ,
    .retired_cnt(retired_cnt)
`endif
  );

  // One-cycle registered read; operand bytes wrap modulo 256.
  always @(posedge clk) begin
    mem_opcode <= mem[mem_addr][2:0];
    mem_a      <= mem[mem_addr + 8'd1];
    mem_b      <= mem[mem_addr + 8'd2];
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int hs;
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    mem[0] = 8'h00; mem[1] = 8'd4;  mem[2] = 8'd1;      // ADD 4,1
    mem[3] = 8'h04; mem[4] = 8'd64; mem[5] = 8'd0;      // JUMP 64
    mem[64] = 8'h01; mem[65] = 8'd7; mem[66] = 8'd9;    // SUB 7,9
    mem[67] = 8'h04; mem[68] = 8'd254; mem[69] = 8'd0;  // JUMP 254
    mem[254] = 8'h02; mem[255] = 8'h55;                 // AND 55,mem[0]

    rst = 1'b1; en = 1'b1; ins_ready = 1'b1;
    tick(); tick();
    chk("rst_addr",   mem_addr,  32'd0);
    chk("rst_valid",  ins_valid, 32'd0);
    chk("rst_halted", halted,    32'd0);
    chk("rst_ins",    {ins_opcode, ins_a, ins_b}, 32'd0);
`ifdef FETCH_STATS_EN
    chk("rst_retired", retired_cnt, 32'd0);
`endif

    // First fetch: valid after the 2nd edge out of reset
    rst = 1'b0;
    tick();
    chk("lat_e1_valid", ins_valid, 32'd0);
    chk("lat_e1_addr",  mem_addr,  32'd0);
    tick();
    chk("lat_e2_valid", ins_valid, 32'd1);
    chk("lat_e2_ins",   {ins_opcode, ins_a, ins_b}, {3'b000, 8'd4, 8'd1});
    tick();
    chk("acc0_addr",  mem_addr,  32'd3);
    chk("acc0_valid", ins_valid, 32'd0);

    // Jump at 3 -> 64, nothing forwarded
    tick();
    chk("jmp_dec_valid", ins_valid, 32'd0);
    tick();
    chk("jmp_addr",  mem_addr,  32'd64);
    chk("jmp_valid", ins_valid, 32'd0);
    tick();
    ins_ready = 1'b0;
    tick();
    chk("sub_valid", ins_valid, 32'd1);
    chk("sub_ins",   {ins_opcode, ins_a, ins_b}, {3'b001, 8'd7, 8'd9});

    // Backpressure: everything held
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("bp_valid", ins_valid, 32'd1);
      chk("bp_ins",   {ins_opcode, ins_a, ins_b}, {3'b001, 8'd7, 8'd9});
      chk("bp_addr",  mem_addr, 32'd64);
    end
    ins_ready = 1'b1;
    tick();
    chk("bp_rel_valid", ins_valid, 32'd0);
    chk("bp_rel_addr",  mem_addr,  32'd67);

    // Jump to 254, accept there, pc wraps to 1
    tick(); tick();
    chk("wrap_jaddr", mem_addr, 32'd254);
    tick(); tick();
    chk("wrap_valid", ins_valid, 32'd1);
    chk("wrap_ins",   {ins_opcode, ins_a, ins_b}, {3'b010, 8'h55, 8'h00});
    tick();
    chk("wrap_addr",  mem_addr,  32'd1);
    chk("wrap_valid0", ins_valid, 32'd0);
`ifdef FETCH_STATS_EN
    chk("retired_3", retired_cnt, 32'd3);
`endif

    // Halt at 6: 0 ADD, 3 OR, 6 HALT
    rst = 1'b1;
    mem[3] = 8'h03; mem[4] = 8'h0A; mem[5] = 8'h0B; mem[6] = 8'h07;
    tick();
    chk("rst2_addr", mem_addr, 32'd0);
    rst = 1'b0;
    tick(); tick();
    chk("h_add_valid", ins_valid, 32'd1);
    tick(); tick(); tick();
    chk("h_or_ins", {ins_valid, ins_opcode, ins_a, ins_b}, {1'b1, 3'b011, 8'h0A, 8'h0B});
    tick(); tick(); tick();
    chk("halt_flag",  halted,    32'd1);
    chk("halt_valid", ins_valid, 32'd0);
    chk("halt_addr",  mem_addr,  32'd6);
    for (int i = 0; i < 20; i++) begin
      ins_ready = i[0];
      tick();
      chk("halt_hold", {halted, ins_valid, mem_addr}, {1'b1, 1'b0, 8'd6});
    end
    ins_ready = 1'b1;
    rst = 1'b1;
    tick();
    chk("halt_rst", {halted, mem_addr}, {1'b0, 8'd0});

    // en=0 holds FETCH; then four accepted ADD/SUB/AND/OR and HALT at 12
    mem[3] = 8'h01; mem[6] = 8'h02; mem[7] = 8'h21; mem[8] = 8'h22;
    mem[9] = 8'h03; mem[10] = 8'h31; mem[11] = 8'h32; mem[12] = 8'h07;
    rst = 1'b0; en = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("en0_hold", {ins_valid, mem_addr}, {1'b0, 8'd0});
    end
    en = 1'b1;
    tick();
    chk("en1_e1_valid", ins_valid, 32'd0);
    hs = 0;
    for (int i = 0; i < 40 && !halted; i++) begin
      tick();
      if (ins_valid) begin
        chk("seq_op", ins_opcode, hs);
        hs++;
      end
    end
    chk("seq_halted", halted,   32'd1);
    chk("seq_count",  hs,       32'd4);
    chk("seq_addr",   mem_addr, 32'd12);
`ifdef FETCH_STATS_EN
    chk("retired_4", retired_cnt, 32'd4);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
